// File: rtl/text_pkg.sv
// Shared constants and state type for the status text panel buffer.
package text_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CHAR_W = 7;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DEPTH  = 256;

    localparam logic [BYTE_W-1:0] BYTE_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] BYTE_LF = 8'h0A;
    localparam logic [BYTE_W-1:0] BYTE_BS = 8'h08;
    localparam logic [BYTE_W-1:0] BYTE_FF = 8'h0C;

    localparam logic [BYTE_W-1:0] PRINT_MIN_DEF  = 8'h20;
    localparam logic [BYTE_W-1:0] PRINT_MAX_DEF  = 8'h7E;
    localparam logic [CHAR_W-1:0] BLANK_CHAR_DEF = 7'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/text_ram_256x7.sv
// 256x7 character RAM: one synchronous write port, one registered read port (read-before-write).
module text_ram_256x7
    import text_pkg::*;
#(
    parameter logic [CHAR_W-1:0] RST_VAL = BLANK_CHAR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [CHAR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [CHAR_W-1:0] rdata_o
);

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [CHAR_W-1:0] rdata_q;

    // Storage array carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Output register samples the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= RST_VAL;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/status_text_buffer.sv
// Status text panel: byte stream command decoder, write cursor and clear sequencer over a 16x16 grid.
module status_text_buffer
    import text_pkg::*;
#(
    parameter logic [CHAR_W-1:0] BLANK_CHAR = BLANK_CHAR_DEF,
    parameter logic [BYTE_W-1:0] PRINT_MIN  = PRINT_MIN_DEF,
    parameter logic [BYTE_W-1:0] PRINT_MAX  = PRINT_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] cursor_xy,
    input  logic [ADDR_W-1:0] char_xy,
    output logic [CHAR_W-1:0] char_code
);

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] cursor_q,  cursor_d;
    logic              ready_q;
    logic              busy_q;

    logic              ram_we_c;
    logic [ADDR_W-1:0] ram_waddr_c;
    logic [CHAR_W-1:0] ram_wdata_c;
    logic              accept_c;

    assign accept_c = wr_valid && ready_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            cursor_q  <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            cursor_q  <= cursor_d;
            ready_q   <= (state_d == IDLE);
            busy_q    <= (state_d == CLEAR);
        end
    end

    // Next state, cursor update and write-port mux between clear sweep and stream bytes.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        cursor_d    = cursor_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = cursor_q;
        ram_wdata_c = wr_data[CHAR_W-1:0];

        unique case (state_q)
            CLEAR: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = clr_cnt_q;
                ram_wdata_c = BLANK_CHAR;
                clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                end
            end
            IDLE: begin
                if (accept_c) begin
                    if (wr_data >= PRINT_MIN && wr_data <= PRINT_MAX) begin
                        ram_we_c = 1'b1;
                        // {row,col} increment wraps col into row and row back to 0.
                        cursor_d = cursor_q + ADDR_W'(1);
                    end else begin
                        case (wr_data)
                            BYTE_CR: cursor_d = {cursor_q[7:4], 4'h0};
                            BYTE_LF: cursor_d = {cursor_q[7:4] + 4'd1, 4'h0};
                            BYTE_BS: begin
                                if (cursor_q[3:0] != 4'h0) begin
                                    cursor_d = {cursor_q[7:4], cursor_q[3:0] - 4'd1};
                                end
                            end
                            BYTE_FF: begin
                                state_d   = CLEAR;
                                clr_cnt_d = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    text_ram_256x7 #(
        .RST_VAL (BLANK_CHAR)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (ram_we_c),
        .waddr_i (ram_waddr_c),
        .wdata_i (ram_wdata_c),
        .raddr_i (char_xy),
        .rdata_o (char_code)
    );

    assign wr_ready  = ready_q;
    assign busy      = busy_q;
    assign cursor_xy = cursor_q;

endmodule
